toggle_rate_monitor: RTL and testbench

TOGGLE_RATE_MONITOR -- requirements
Module: toggle_rate_monitor

---
 rtl/toggle_rate_monitor_pkg.sv | 19 +
 rtl/toggle_rate_monitor_rate_compare.sv | 30 +++
 rtl/toggle_rate_monitor.sv | 149 ++++++++++++++
 tb/tb_toggle_rate_monitor.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/toggle_rate_monitor_pkg.sv
// Shared definitions for the toggle-rate monitor.
// The WINDOW/SETTLE defaults match the toggle generator's 100-cycle
// period, and the rate width bounds both the count and the tolerance.
package toggle_rate_monitor_pkg;

  localparam int unsigned RATE_W     = 7;
  localparam int unsigned DEF_WINDOW = 100;
  localparam int unsigned DEF_SETTLE = 64;

  typedef logic [RATE_W-1:0] rate_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_MEASURE = 2'd2,
    ST_REPORT  = 2'd3
  } state_t;

endpackage

// File: rtl/toggle_rate_monitor_rate_compare.sv
// rate_compare: checks a measured transition count against an expected
// rate with an absolute tolerance.
// Ports:
//   count    - measured transitions in the window
//   exp_rate - expected transitions in the window
//   tol      - allowed absolute deviation
//   pass     - 1 when |count - exp_rate| <= tol
module rate_compare
  import toggle_rate_monitor_pkg::*;
(
  input  logic [RATE_W-1:0] count,
  input  logic [RATE_W-1:0] exp_rate,
  input  logic [RATE_W-1:0] tol,
  output logic              pass
);

  // One bit wider than the operands; the larger operand is always the
  // minuend, so the difference never wraps.
  logic [RATE_W:0] diff;

  always_comb begin
    if (count >= exp_rate) begin
      diff = {1'b0, count} - {1'b0, exp_rate};
    end else begin
      diff = {1'b0, exp_rate} - {1'b0, count};
    end
    pass = (diff <= {1'b0, tol});
  end

endmodule

// File: rtl/toggle_rate_monitor.sv
// toggle_rate_monitor: counts transitions of sample_i over fixed windows
// and reports whether the count is within tol of exp_rate.
// Ports:
//   clk, rst   - rising-edge clock, synchronous active-high reset
//   en         - monitor enable level
//   sample_i   - observed activity stream
//   exp_rate   - expected transitions per window (latched per window)
//   tol        - allowed absolute deviation (latched per window)
//   clr_err    - pulse clearing err_sticky
//   meas_rate  - transition count of the last completed window
//   meas_valid - one-cycle pulse for a new meas_rate/pass result
//   pass       - result of the last completed window
//   err_sticky - set by any failing window until cleared
//   win_cnt    - completed window count (saturating)
//   busy       - high whenever the FSM is not idle
module toggle_rate_monitor
  import toggle_rate_monitor_pkg::*;
#(
  parameter int unsigned WINDOW = DEF_WINDOW,
  parameter int unsigned SETTLE = DEF_SETTLE,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              sample_i,
  input  logic [RATE_W-1:0] exp_rate,
  input  logic [RATE_W-1:0] tol,
  input  logic              clr_err,
  output logic [RATE_W-1:0] meas_rate,
  output logic              meas_valid,
  output logic              pass,
  output logic              err_sticky,
  output logic [CNT_W-1:0]  win_cnt,
  output logic              busy
);

  localparam logic [7:0]        SET_LAST = 8'(SETTLE - 1);
  localparam logic [RATE_W-1:0] WIN_LAST = RATE_W'(WINDOW - 1);

  state_t            state;
  state_t            state_nx;
  logic              s1;
  logic              s2;
  logic              trans;
  logic [7:0]        set_cnt;
  logic [RATE_W-1:0] cyc_cnt;
  logic [RATE_W-1:0] tcnt;
  logic [RATE_W-1:0] exp_q;
  logic [RATE_W-1:0] tol_q;
  logic              cmp_pass;
  logic              enter_measure;

  assign trans         = s1 ^ s2;
  assign busy          = (state != ST_IDLE);
  assign enter_measure = (state_nx == ST_MEASURE) && (state != ST_MEASURE);

  rate_compare u_cmp (
    .count    (tcnt),
    .exp_rate (exp_q),
    .tol      (tol_q),
    .pass     (cmp_pass)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (en) state_nx = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (!en)                      state_nx = ST_IDLE;
        else if (set_cnt == SET_LAST) state_nx = ST_MEASURE;
      end
      ST_MEASURE: begin
        if (!en)                      state_nx = ST_IDLE;
        else if (cyc_cnt == WIN_LAST) state_nx = ST_REPORT;
      end
      ST_REPORT: begin
        state_nx = en ? ST_MEASURE : ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      set_cnt    <= '0;
      cyc_cnt    <= '0;
      tcnt       <= '0;
      exp_q      <= '0;
      tol_q      <= '0;
      meas_rate  <= '0;
      meas_valid <= 1'b0;
      pass       <= 1'b0;
      err_sticky <= 1'b0;
      win_cnt    <= '0;
    end else begin
      s1         <= sample_i;
      s2         <= s1;
      meas_valid <= 1'b0;

      if (state == ST_SETTLE) begin
        set_cnt <= set_cnt + 8'd1;
      end else begin
        set_cnt <= '0;
      end

      // Counters clear on the edge that enters MEASURE, so every MEASURE
      // cycle (first through last) contributes its transition flag.
      if (enter_measure) begin
        cyc_cnt <= '0;
        tcnt    <= '0;
        exp_q   <= exp_rate;
        tol_q   <= tol;
      end else if (state == ST_MEASURE) begin
        cyc_cnt <= cyc_cnt + 1'b1;
        if (trans && (tcnt != '1)) tcnt <= tcnt + 1'b1;
      end

      // Results register during REPORT so they appear one cycle later,
      // independent of en, so a report in flight is always delivered.
      if (state == ST_REPORT) begin
        meas_valid <= 1'b1;
        meas_rate  <= tcnt;
        pass       <= cmp_pass;
        if (win_cnt != '1) win_cnt <= win_cnt + 1'b1;
      end

      // A failing report beats a coincident clear.
      if ((state == ST_REPORT) && !cmp_pass) begin
        err_sticky <= 1'b1;
      end else if (clr_err) begin
        err_sticky <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_toggle_rate_monitor.sv
module tb_toggle_rate_monitor;

  localparam int W = 100;
  localparam int S = 64;
  localparam int FIRST = S + W + 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        sample_i;
  logic [6:0]  exp_rate;
  logic [6:0]  tol;
  logic        clr_err;
  logic [6:0]  meas_rate;
  logic        meas_valid;
  logic        pass;
  logic        err_sticky;
  logic [15:0] win_cnt;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int mode  = 0;  // 0: constant 0, 1: toggle each cycle, 2: 0,0,1,1

  toggle_rate_monitor #(.WINDOW(W), .SETTLE(S), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .sample_i   (sample_i),
    .exp_rate   (exp_rate),
    .tol        (tol),
    .clr_err    (clr_err),
    .meas_rate  (meas_rate),
    .meas_valid (meas_valid),
    .pass       (pass),
    .err_sticky (err_sticky),
    .win_cnt    (win_cnt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    case (mode)
      0:       sample_i = 1'b0;
      1:       sample_i = ~sample_i;
      default: sample_i = cyc[1];
    endcase
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; clr_err = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic wait_valid(input int limit, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!meas_valid && n < limit);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; clr_err = 1'b1; sample_i = 1'b0;
    exp_rate = 7'd0; tol = 7'd0; mode = 0;
    tick(); tick(); tick();
    total++; if (meas_rate !== 7'd0) begin bad++; $display("FAIL reset_rate: got %0d want 0", meas_rate); end
    total++; if (meas_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", meas_valid); end
    total++; if (pass !== 1'b0) begin bad++; $display("FAIL reset_pass: got %0b want 0", pass); end
    total++; if (err_sticky !== 1'b0) begin bad++; $display("FAIL reset_err: got %0b want 0", err_sticky); end
    total++; if (win_cnt !== 16'd0) begin bad++; $display("FAIL reset_wincnt: got %0d want 0", win_cnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
    en = 1'b0; clr_err = 1'b0; rst = 1'b0;
  endtask

  task automatic test_quiet();
    int early = 0;
    do_reset();
    mode = 0; exp_rate = 7'd0; tol = 7'd0; en = 1'b1;
    tick();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL quiet_busy: got %0b want 1", busy); end
    for (int k = 2; k < FIRST; k++) begin
      tick();
      if (meas_valid) early++;
    end
    total++; if (early != 0) begin bad++; $display("FAIL quiet_early_valid: got %0d pulses want 0", early); end
    tick();
    total++; if (meas_valid !== 1'b1) begin bad++; $display("FAIL quiet_valid: got %0b want 1", meas_valid); end
    total++; if (meas_rate !== 7'd0) begin bad++; $display("FAIL quiet_rate: got %0d want 0", meas_rate); end
    total++; if (pass !== 1'b1) begin bad++; $display("FAIL quiet_pass: got %0b want 1", pass); end
    total++; if (err_sticky !== 1'b0) begin bad++; $display("FAIL quiet_err: got %0b want 0", err_sticky); end
    total++; if (win_cnt !== 16'd1) begin bad++; $display("FAIL quiet_wincnt: got %0d want 1", win_cnt); end
    tick();
    total++; if (meas_valid !== 1'b0) begin bad++; $display("FAIL quiet_pulse_width: got %0b want 0", meas_valid); end
  endtask

  task automatic test_fast_toggle();
    int n;
    do_reset();
    mode = 1; exp_rate = 7'd50; tol = 7'd5; en = 1'b1;
    wait_valid(FIRST + 20, n);
    total++; if (n != FIRST) begin bad++; $display("FAIL toggle_latency: got %0d want %0d", n, FIRST); end
    total++; if (meas_rate !== 7'd100) begin bad++; $display("FAIL toggle_rate: got %0d want 100", meas_rate); end
    total++; if (pass !== 1'b0) begin bad++; $display("FAIL toggle_pass: got %0b want 0", pass); end
    total++; if (err_sticky !== 1'b1) begin bad++; $display("FAIL toggle_err: got %0b want 1", err_sticky); end
    total++; if (win_cnt !== 16'd1) begin bad++; $display("FAIL toggle_wincnt: got %0d want 1", win_cnt); end
  endtask

  task automatic test_back_to_back();
    int n;
    do_reset();
    mode = 2; exp_rate = 7'd50; tol = 7'd0; en = 1'b1;
    wait_valid(FIRST + 20, n);
    total++; if (n != FIRST) begin bad++; $display("FAIL b2b_latency: got %0d want %0d", n, FIRST); end
    for (int w = 0; w < 3; w++) begin
      if (w > 0) begin
        wait_valid(W + 20, n);
        total++; if (n != W + 1) begin bad++; $display("FAIL b2b_spacing: got %0d want %0d", n, W + 1); end
      end
      total++; if (meas_rate !== 7'd50) begin bad++; $display("FAIL b2b_rate: got %0d want 50", meas_rate); end
      total++; if (pass !== 1'b1) begin bad++; $display("FAIL b2b_pass: got %0b want 1", pass); end
    end
    total++; if (win_cnt !== 16'd3) begin bad++; $display("FAIL b2b_wincnt: got %0d want 3", win_cnt); end
    total++; if (err_sticky !== 1'b0) begin bad++; $display("FAIL b2b_err: got %0b want 0", err_sticky); end
  endtask

  task automatic test_en_drop();
    int n;
    int stray = 0;
    do_reset();
    mode = 1; exp_rate = 7'd50; tol = 7'd5; en = 1'b1;
    wait_valid(FIRST + 20, n);
    repeat (39) tick();  // now in MEASURE cycle 40 of the second window
    en = 1'b0;
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL drop_busy: got %0b want 0", busy); end
    repeat (150) begin
      tick();
      if (meas_valid) stray++;
    end
    total++; if (stray != 0) begin bad++; $display("FAIL drop_no_valid: got %0d pulses want 0", stray); end
    total++; if (meas_rate !== 7'd100) begin bad++; $display("FAIL drop_rate_hold: got %0d want 100", meas_rate); end
    total++; if (pass !== 1'b0) begin bad++; $display("FAIL drop_pass_hold: got %0b want 0", pass); end
    total++; if (win_cnt !== 16'd1) begin bad++; $display("FAIL drop_wincnt: got %0d want 1", win_cnt); end
  endtask

  task automatic test_report_drop();
    int n;
    do_reset();
    mode = 2; exp_rate = 7'd50; tol = 7'd0; en = 1'b1;
    wait_valid(FIRST + 20, n);
    repeat (W) tick();  // REPORT cycle of the second window
    en = 1'b0;
    tick();
    total++; if (meas_valid !== 1'b1) begin bad++; $display("FAIL rdrop_valid: got %0b want 1", meas_valid); end
    total++; if (meas_rate !== 7'd50) begin bad++; $display("FAIL rdrop_rate: got %0d want 50", meas_rate); end
    total++; if (win_cnt !== 16'd2) begin bad++; $display("FAIL rdrop_wincnt: got %0d want 2", win_cnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rdrop_busy: got %0b want 0", busy); end
  endtask

  task automatic test_clr_race();
    int n;
    do_reset();
    mode = 1; exp_rate = 7'd50; tol = 7'd5; en = 1'b1;
    wait_valid(FIRST + 20, n);
    repeat (W) tick();  // REPORT cycle of a failing window
    clr_err = 1'b1; exp_rate = 7'd100; tol = 7'd0;
    tick();
    clr_err = 1'b0;
    total++; if (meas_valid !== 1'b1) begin bad++; $display("FAIL race_valid: got %0b want 1", meas_valid); end
    total++; if (pass !== 1'b0) begin bad++; $display("FAIL race_latched_pass: got %0b want 0", pass); end
    total++; if (err_sticky !== 1'b1) begin bad++; $display("FAIL race_err_set_wins: got %0b want 1", err_sticky); end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    total++; if (err_sticky !== 1'b0) begin bad++; $display("FAIL race_err_cleared: got %0b want 0", err_sticky); end
    wait_valid(W + 20, n);
    total++; if (n != W) begin bad++; $display("FAIL race_spacing: got %0d want %0d", n, W); end
    total++; if (pass !== 1'b1) begin bad++; $display("FAIL race_pass: got %0b want 1", pass); end
    total++; if (err_sticky !== 1'b0) begin bad++; $display("FAIL race_err_stays_clear: got %0b want 0", err_sticky); end
    total++; if (win_cnt !== 16'd3) begin bad++; $display("FAIL race_wincnt: got %0d want 3", win_cnt); end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    mode = 1; exp_rate = 7'd50; tol = 7'd5; en = 1'b1;
    wait_valid(FIRST + 20, n);
    repeat (20) tick();
    rst = 1'b1; clr_err = 1'b0;
    tick();
    total++; if (meas_rate !== 7'd0) begin bad++; $display("FAIL rmid_rate: got %0d want 0", meas_rate); end
    total++; if (meas_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid: got %0b want 0", meas_valid); end
    total++; if (pass !== 1'b0) begin bad++; $display("FAIL rmid_pass: got %0b want 0", pass); end
    total++; if (err_sticky !== 1'b0) begin bad++; $display("FAIL rmid_err: got %0b want 0", err_sticky); end
    total++; if (win_cnt !== 16'd0) begin bad++; $display("FAIL rmid_wincnt: got %0d want 0", win_cnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy: got %0b want 0", busy); end
    rst = 1'b0;
    tick();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rmid_restart_busy: got %0b want 1", busy); end
    wait_valid(FIRST + 20, n);
    total++; if (n != FIRST - 1) begin bad++; $display("FAIL rmid_restart_latency: got %0d want %0d", n, FIRST - 1); end
    total++; if (meas_rate !== 7'd100) begin bad++; $display("FAIL rmid_restart_rate: got %0d want 100", meas_rate); end
    total++; if (win_cnt !== 16'd1) begin bad++; $display("FAIL rmid_restart_wincnt: got %0d want 1", win_cnt); end
  endtask

  initial begin
    test_reset();
    test_quiet();
    test_fast_toggle();
    test_back_to_back();
    test_en_drop();
    test_report_drop();
    test_clr_race();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
